if_id_skid_reg: RTL and testbench
=================================

Name: if_id_skid_reg

Overview:
- Parametrised IF/ID pipeline register that succeeds the plain stall/flush latch.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so fetch can issue one more instruction after decode stops accepting without losing it.
- Sits between the fetch unit (PC register plus I-cache) and the decode stage.
- Keeps the existing stall and flush semantics: flush injects a NOP bubble; stall holds the output.

Parameters:
- PC_W, 32, width of the PC payload.
- INSTR_W, 32, width of the instruction payload.
- NOP_INSTR, 32'h00000013, instruction driven whenever no valid entry is held (ADDI x0,x0,0).
- PC_RST, 32'h00000000, out_pc value after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  squashes all held entries; the NOP bubble appears on the next cycle.
- stall  in  1  holds the output entry; equivalent to out_ready=0.
- in_valid  in  1  fetch offers in_pc/in_instr.
- in_ready  out  1  register can accept; in_ready = (state != ST_FULL).
- in_pc  in  PC_W  fetched PC.
- in_instr  in  INSTR_W  fetched instruction.
- out_valid  out  1  out_pc/out_instr hold a real instruction.
- out_ready  in  1  decode consumes the entry.
- out_pc  out  PC_W  to ID stage.
- out_instr  out  INSTR_W  to ID stage; equals NOP_INSTR when out_valid=0.
- occupancy  out  2  number of held entries, 0 to 2.

Behaviour:
- Internal signals: push = in_valid & in_ready; pop = out_valid & out_ready & ~stall.
- Reset (reset_n=0, asynchronous, any state):
  - state=ST_EMPTY, out_valid=0, out_instr=NOP_INSTR, out_pc=PC_RST.
  - Skid entry invalid, occupancy=0, in_ready=1.
  - Reset asserted mid-transfer discards all entries.
- Priority: reset > flush > handshake.
- flush=1:
  - Next state is ST_EMPTY; main_instr<=NOP_INSTR; main_pc<=in_pc (same as the existing flush); skid is invalidated.
  - Any push in that cycle is dropped.
  - A flush together with a stall still flushes.
- State machine, with main entry = output register and skid = second entry:
  - ST_EMPTY:
    - push -> ST_ONE, main<=in.
    - otherwise stay.
  - ST_ONE:
    - push & ~pop -> ST_FULL, skid<=in.
    - pop & ~push -> ST_EMPTY, main_instr<=NOP_INSTR, main_pc unchanged.
    - push & pop -> ST_ONE, main<=in.
    - neither -> hold.
  - ST_FULL:
    - in_ready=0, so push is impossible.
    - pop -> ST_ONE, main<=skid, skid invalidated.
    - ~pop -> hold both entries.
- Ordering: strictly FIFO; skid is never bypassed.
- Timing:
  - Latency is 1 cycle from push to out_valid.
  - Sustained throughput is 1 instruction/cycle with out_ready=1 and stall=0.
- Outputs: out_valid = (state != ST_EMPTY). in_ready and occupancy decode from the state register only; there is no combinational path from out_ready to in_ready.
- Payload changes only on the transitions listed above; it is stable while stalled.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- When defined, adds three outputs:
  - stall_cycles[31:0]: increments when out_valid & ~pop.
  - flush_count[31:0]: increments per flush cycle.
  - full_cycles[31:0]: increments when state==ST_FULL.
- Counters reset to 0 on reset_n and wrap at 2^32-1 -> 0.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - RV_NOP = 32'h00000013.
  - if_id_state_e enum: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Typedef if_id_payload_t {pc, instr}.
- One natural sub-module, if_id_perf_cnt, holding the three counters; it is instantiated only under IF_ID_PERF_CNT_EN.

Test Plan:
- Reset: reset_n low mid-cycle with state ST_FULL -> immediately out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1, occupancy=0.
- Streaming: push PCs 0x0,0x4,0x8,0xC on consecutive cycles with out_ready=1 -> the same PCs appear on out_pc, each 1 cycle later, with out_valid high for 4 consecutive cycles and occupancy=1 throughout.
- Backpressure: push 0x100 then 0x104 with out_ready=0 -> occupancy=2 and in_ready=0; 0x108 is held off. Raise out_ready -> 0x100, 0x104, 0x108 come out in order with none lost.
- Stall vs ready: out_ready=1, stall=1 for 3 cycles with 0x200 held -> out_pc stays 0x200 and the entry is not consumed.
- Flush: occupancy=2 holding 0x300 and 0x304, with flush=1 while in_valid=1 carries in_pc=0x400 -> next cycle out_valid=0, out_instr=NOP, out_pc=0x400, occupancy=0, and 0x400 is not enqueued.
- Perf counters (IF_ID_PERF_CNT_EN defined): run the backpressure scenario followed by one flush -> full_cycles and stall_cycles equal the bench-counted cycle totals, and flush_count=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the canonical RISC-V NOP, the IF/ID occupancy states
// and the fetch payload record.
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h00000013;

  // The state encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } if_id_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

endpackage

// File: rtl/if_id_perf_cnt.sv
// Free-running 32-bit event counters for the IF/ID skid register.
// Instantiated only when IF_ID_PERF_CNT_EN is defined.
module if_id_perf_cnt (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_inc,
  input  logic        flush_inc,
  input  logic        full_inc,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
  output logic [31:0] full_cycles
);

  // Plain +1 so each counter wraps naturally from 2^32-1 back to 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
      full_cycles  <= '0;
    end else begin
      if (stall_inc) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_count  <= flush_count + 32'd1;
      if (full_inc)  full_cycles  <= full_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define IF_ID_PERF_CNT_EN to add the stall/flush/full performance counters.
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(RV_NOP),
  parameter logic [PC_W-1:0]     PC_RST    = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy,
  output logic [1:0]         state_dbg
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        flush_count,
  output logic [31:0]        full_cycles
`endif
);

  // Handshake: a transfer happens on a rising edge when valid and ready are both
  // high; valid never waits on ready, and stall acts as a forced out_ready=0.

  if_id_state_e       state_q;
  logic [PC_W-1:0]    main_pc_q;
  logic [INSTR_W-1:0] main_instr_q;
  logic [PC_W-1:0]    skid_pc_q;
  logic [INSTR_W-1:0] skid_instr_q;

  logic push;
  logic pop;

  // Ready and valid decode from the state register only: no out_ready->in_ready path.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;
  assign state_dbg = state_q;
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      main_pc_q    <= PC_RST;
      main_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else if (flush) begin
      // The bubble carries the PC being fetched, matching the old stall/flush latch.
      state_q      <= ST_EMPTY;
      main_pc_q    <= in_pc;
      main_instr_q <= NOP_INSTR;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_q      <= ST_ONE;
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            state_q      <= ST_FULL;
            skid_pc_q    <= in_pc;
            skid_instr_q <= in_instr;
          end else if (pop && !push) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= NOP_INSTR;
          end else if (push && pop) begin
            main_pc_q    <= in_pc;
            main_instr_q <= in_instr;
          end
        end
        ST_FULL: begin
          // Skid always drains into main, keeping strict FIFO order.
          if (pop) begin
            state_q      <= ST_ONE;
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
          end
        end
        default: begin
          state_q      <= ST_EMPTY;
          main_instr_q <= NOP_INSTR;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  if_id_perf_cnt u_perf_cnt (
    .clk          (clk),
    .reset_n      (reset_n),
    .stall_inc    (out_valid & ~pop),
    .flush_inc    (flush),
    .full_inc     (state_q == ST_FULL),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .full_cycles  (full_cycles)
  );
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Self-checking bench for if_id_skid_reg: directed scenarios plus a FIFO scoreboard
// that follows every cycle.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occupancy;
  logic [1:0]  state_dbg;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic [31:0] full_cycles;
`endif

  int tests_run = 0;
  int failures  = 0;

  logic [63:0] exp_q[$];
  int          exp_stall = 0;
  int          exp_flush = 0;
  int          exp_full  = 0;
  int          mon_sz;
  logic        mon_pop;
  logic        mon_push;
  logic [63:0] mon_head;

  if_id_skid_reg dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .full_cycles  (full_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      exp_stall = 0;
      exp_flush = 0;
      exp_full  = 0;
    end else begin
      mon_sz = exp_q.size();
      tests_run++;
      if (occupancy !== 2'(mon_sz)) begin
        failures++; $display("FAIL sb_occupancy: got %0d want %0d", occupancy, mon_sz);
      end
      tests_run++;
      if (out_valid !== (mon_sz != 0)) begin
        failures++; $display("FAIL sb_out_valid: got %b want %b", out_valid, mon_sz != 0);
      end
      tests_run++;
      if (in_ready !== (mon_sz < 2)) begin
        failures++; $display("FAIL sb_in_ready: got %b want %b", in_ready, mon_sz < 2);
      end
      if (mon_sz == 0) begin
        tests_run++;
        if (out_instr !== NOP) begin
          failures++; $display("FAIL sb_nop: got %h want %h", out_instr, NOP);
        end
      end
      mon_pop  = (mon_sz > 0) && out_ready && !stall;
      mon_push = in_valid && (mon_sz < 2) && !flush;
      if (mon_pop) begin
        mon_head = exp_q[0];
        tests_run++;
        if ({out_pc, out_instr} !== mon_head) begin
          failures++;
          $display("FAIL sb_payload: got pc=%h instr=%h want pc=%h instr=%h",
                   out_pc, out_instr, mon_head[63:32], mon_head[31:0]);
        end
      end
      if (mon_sz > 0 && !mon_pop) exp_stall++;
      if (mon_sz == 2) exp_full++;
      if (flush) begin
        exp_flush++;
        exp_q.delete();
      end else begin
        if (mon_pop) void'(exp_q.pop_front());
        if (mon_push) exp_q.push_back({in_pc, in_instr});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic v, input logic [31:0] pc);
    @(posedge clk); #1;
    in_valid = v;
    in_pc    = pc;
    in_instr = $urandom();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_pc = '0; in_instr = '0;
    #12;
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_instr !== NOP) begin failures++; $display("FAIL rst_out_instr: got %h want %h", out_instr, NOP); end
    tests_run++; if (out_pc !== 32'h0) begin failures++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
    @(posedge clk); #1 reset_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h40; in_instr = $urandom();
    drive_in(1'b1, 32'h44);
    drive_in(1'b0, 32'h0);
    @(negedge clk);
    tests_run++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL rst_fill_state: got %0d want 2", state_dbg); end
    // asynchronous reset mid-cycle while full
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
    tests_run++; if (out_instr !== NOP) begin failures++; $display("FAIL arst_out_instr: got %h want %h", out_instr, NOP); end
    tests_run++; if (out_pc !== 32'h0) begin failures++; $display("FAIL arst_out_pc: got %h want 0", out_pc); end
    tests_run++; if (in_ready !== 1'b1) begin failures++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
    tests_run++; if (occupancy !== 2'd0) begin failures++; $display("FAIL arst_occupancy: got %0d want 0", occupancy); end
    tests_run++; if (state_dbg !== 2'd0) begin failures++; $display("FAIL arst_state: got %0d want 0", state_dbg); end
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_in(i < 4, 32'(4 * i));
      @(negedge clk);
      if (i >= 1) begin
        tests_run++; if (out_pc !== 32'(4 * (i - 1))) begin failures++; $display("FAIL stream_pc%0d: got %h want %h", i, out_pc, 4 * (i - 1)); end
        tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid%0d: got %b want 1", i, out_valid); end
        tests_run++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy); end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc[3];
    int          idx;
    logic        accepted;
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_instr = $urandom();
    drive_in(1'b1, 32'h104);
    drive_in(1'b1, 32'h108);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests_run++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ%0d: got %0d want 2", k, occupancy); end
      tests_run++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready); end
      tests_run++; if (out_pc !== 32'h100) begin failures++; $display("FAIL bp_hold_pc%0d: got %h want 100", k, out_pc); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    idx = 0;
    accepted = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) accepted = 1'b1;
      if (out_valid && idx < 3) begin
        tests_run++;
        if (out_pc !== exp_pc[idx]) begin failures++; $display("FAIL bp_order%0d: got %h want %h", idx, out_pc, exp_pc[idx]); end
        idx++;
      end
      @(posedge clk); #1;
      if (accepted) in_valid = 1'b0;
    end
    tests_run++; if (idx != 3) begin failures++; $display("FAIL bp_drain_count: got %0d want 3", idx); end
  endtask

  task automatic test_stall();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200; in_instr = $urandom();
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (out_pc !== 32'h200) begin failures++; $display("FAIL stall_pc%0d: got %h want 200", k, out_pc); end
      tests_run++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid%0d: got %b want 1", k, out_valid); end
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    tests_run++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stall_kept: got %0d want 1", occupancy); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300; in_instr = $urandom();
    drive_in(1'b1, 32'h304);
    drive_in(1'b1, 32'h400);
    flush = 1'b1;
    @(negedge clk);
    tests_run++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ: got %0d want 2", occupancy); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    tests_run++; if (out_instr !== NOP) begin failures++; $display("FAIL flush_instr: got %h want %h", out_instr, NOP); end
    tests_run++; if (out_pc !== 32'h400) begin failures++; $display("FAIL flush_pc: got %h want 400", out_pc); end
    tests_run++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    // flush with stall and a push offered from the one-entry state
    drive_in(1'b1, 32'h500);
    drive_in(1'b1, 32'h504);
    flush = 1'b1; stall = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_stall_occ: got %0d want 0", occupancy); end
    tests_run++; if (out_pc !== 32'h504) begin failures++; $display("FAIL flush_stall_pc: got %h want 504", out_pc); end
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_enq: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = pc;
      in_instr  = $urandom();
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      pc        = pc + 32'd4;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    tests_run++; if (occupancy !== 2'd0) begin failures++; $display("FAIL b2b_drained: got %0d want 0", occupancy); end
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_perf();
    @(posedge clk); #1;
    tests_run++; if (full_cycles !== 32'(exp_full)) begin failures++; $display("FAIL perf_full: got %0d want %0d", full_cycles, exp_full); end
    tests_run++; if (stall_cycles !== 32'(exp_stall)) begin failures++; $display("FAIL perf_stall: got %0d want %0d", stall_cycles, exp_stall); end
    tests_run++; if (flush_count !== 32'(exp_flush)) begin failures++; $display("FAIL perf_flush: got %0d want %0d", flush_count, exp_flush); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall();
    test_flush();
`ifdef IF_ID_PERF_CNT_EN
    test_perf();
`endif
    test_back_to_back();
`ifdef IF_ID_PERF_CNT_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
